spi_slave_shift_engine: RTL
===========================

// Module: spi_slave_shift_engine
// PURPOSE
//   SPI target (slave) shift engine, i_clk domain, for bring-up loopback against our SPI master datapath.
//   Oversamples external SCLK/CS_N/MOSI through synchronisers.
//   Shifts received MOSI words into o_rx_data and drives o_MISO from a 1-entry TX holding register.
//   Supports all four CPOL/CPHA modes, 8/16-bit words, MSB first, multi-word frames under one CS_N.
// PARAMETERS
//   SYNC_STAGES   2        synchroniser depth on i_SCLK, i_CS_N, i_MOSI (>=2)
//   UNDERRUN_FILL 16'h0000 word shifted out when no TX data is held at word load
// PORTS
//   i_clk          in   1   system clock; SCLK must be <= i_clk/8
//   i_rst          in   1   asynchronous, active-high reset
//   i_cpol         in   1   SCLK idle level
//   i_cpha         in   1   0: sample on leading edge; 1: sample on trailing edge
//   i_wls          in   1   1: 16-bit word, 0: 8-bit word (low byte); latched at each word load
//   i_tx_data      in   16  next word to send (8-bit mode uses [7:0])
//   i_tx_valid     in   1   TX write request
//   o_tx_ready     out  1   holding register empty
//   o_rx_data      out  16  last complete received word (8-bit: {8'h00,byte})
//   o_rx_valid     out  1   1-cycle pulse, o_rx_data updated
//   o_tx_underrun  out  1   1-cycle pulse, UNDERRUN_FILL loaded
//   o_frame_abort  out  1   1-cycle pulse, CS_N rose mid-word
//   o_busy         out  1   CS_N (synchronised) asserted
//   i_SCLK         in   1   SPI clock from master
//   i_CS_N         in   1   chip select, active low
//   i_MOSI         in   1   master-out data
//   o_MISO         out  1   slave-out data
//   o_MISO_oe      out  1   MISO output enable (tristate control)
// BEHAVIOUR
//   Reset: o_MISO=0, o_MISO_oe=0, o_tx_ready=1, o_rx_valid=0, o_rx_data=0, o_tx_underrun=0,
//     o_frame_abort=0, o_busy=0; holding empty; shift regs/counters 0; FSM=IDLE. Reset mid-frame = same.
//   Edges: detected on last sync stage vs previous. Leading = leaves CPOL level; trailing = returns.
//     sample_edge = cpha ? trailing : leading; shift_edge = cpha ? leading : trailing.
//   Holding reg: write when i_tx_valid && o_tx_ready; o_tx_ready = ~hold_full (registered).
//   Word load: moves holding -> tx_shift, frees holding, latches wls.
//     Holding empty but i_tx_valid high that cycle: i_tx_data loaded directly, no underrun.
//     Otherwise empty: UNDERRUN_FILL loaded, o_tx_underrun pulses.
//   FSM IDLE: o_MISO_oe=0, o_busy=0; sync CS_N fall -> LOAD.
//   FSM LOAD (1 cycle): word load; o_MISO_oe=1; o_MISO=MSB of word (bit 15 or 7); rx_cnt=0; tx_cnt=0 -> ACTIVE.
//   FSM ACTIVE:
//     sample_edge: rx_shift <= {rx_shift,MOSI}; rx_cnt++.
//       At rx_cnt==N, o_rx_data <= word; o_rx_valid pulses the next cycle; rx_cnt=0.
//     shift_edge, CPHA=0: tx_cnt 1..N-1 drive bits N-2..0.
//       The Nth shift edge performs a word load and drives the new MSB; tx_cnt=0.
//     shift_edge, CPHA=1: first edge of each word keeps MSB (already driven).
//       Edges 2..N drive bits N-2..0. The (N+1)th edge does a word load, drives new MSB, and counts as edge 1.
//     Sync CS_N rise -> IDLE: o_MISO_oe=0 the same cycle; partial rx/tx discarded.
//       o_frame_abort pulses iff rx_cnt!=0. Holding reg content kept.
//   Simultaneous CS_N rise and Nth sample: word completes (o_rx_valid), no abort.
//   CS_N fall while in LOAD cannot occur (1 cycle); glitches shorter than SYNC_STAGES are not required to be rejected.
//   Latency: external sample edge -> o_rx_valid <= SYNC_STAGES+2 i_clk cycles.
// TESTING
//   Mode0, wls=1, tx 16'hA5C3 pre-loaded, MOSI 16'h1234 -> MISO bits A5C3 MSB-first, o_rx_data=16'h1234, one o_rx_valid.
//   Modes 1/2/3, wls=0, tx 8'h96, MOSI 8'h5A -> MISO 1001_0110, o_rx_data=16'h005A each mode.
//   Two words in one CS_N, second tx written mid-word-1 -> both words out back-to-back, two o_rx_valid, no underrun.
//   Holding empty at CS_N fall -> o_tx_underrun pulse, MISO shifts UNDERRUN_FILL, o_tx_ready stays 1.
//   CS_N raised after 5 bits -> o_frame_abort pulse, no o_rx_valid, o_MISO_oe=0; next frame correct.
//   i_rst pulsed mid-word -> all outputs at reset values; subsequent mode-0 frame 16'hBEEF received intact.

Source files
------------

// File: rtl/spi_slave_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_slave_shift_engine
//   SPI target shift engine running entirely in the i_clk domain. The external
//   SCLK, CS_N and MOSI pins are oversampled through synchronisers. SCLK edges
//   are recovered by comparing the last synchroniser stage with its previous
//   value. Handles all four CPOL/CPHA modes, 8- or 16-bit words sent MSB first,
//   and back-to-back words under one CS_N.
//
// Parameters
//   SYNC_STAGES    synchroniser depth on i_SCLK / i_CS_N / i_MOSI (>= 2)
//   UNDERRUN_FILL  word shifted out when nothing is available at a word load
//
// Ports
//   i_clk, i_rst        system clock, asynchronous active-high reset
//   i_cpol, i_cpha      SPI mode selection
//   i_wls               1: 16-bit words, 0: 8-bit words (latched at word load)
//   i_tx_data/valid     TX write into the 1-entry holding register
//   o_tx_ready          holding register empty
//   o_rx_data/valid     last complete received word, 1-cycle valid pulse
//   o_tx_underrun       pulse: UNDERRUN_FILL was loaded
//   o_frame_abort       pulse: CS_N rose with a partial word received
//   o_busy              frame in progress (synchronised CS_N asserted)
//   i_SCLK, i_CS_N      SPI clock and chip select from the master
//   i_MOSI, o_MISO      serial data in / out
//   o_MISO_oe           MISO tristate enable
// -----------------------------------------------------------------------------
module spi_slave_shift_engine #(
    parameter int          SYNC_STAGES   = 2,
    parameter logic [15:0] UNDERRUN_FILL = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpol,
    input  logic        i_cpha,
    input  logic        i_wls,
    input  logic [15:0] i_tx_data,
    input  logic        i_tx_valid,
    output logic        o_tx_ready,
    output logic [15:0] o_rx_data,
    output logic        o_rx_valid,
    output logic        o_tx_underrun,
    output logic        o_frame_abort,
    output logic        o_busy,
    input  logic        i_SCLK,
    input  logic        i_CS_N,
    input  logic        i_MOSI,
    output logic        o_MISO,
    output logic        o_MISO_oe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;

    logic        sclk_s, cs_s, mosi_s;
    logic        lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;

    logic [15:0] hold_q;
    logic        hold_full_q;
    logic [15:0] tx_word_q;
    logic        wls_q;
    logic [4:0]  tx_cnt_q;
    logic [14:0] rx_shift_q;
    logic [4:0]  rx_cnt_q;
    logic [15:0] rx_data_q;
    logic        rx_valid_q, underrun_q, abort_q, miso_q;

    logic [4:0]  n_bits;
    logic        rx_done, tx_wrap, load_word, frame_end;
    logic [15:0] load_data;
    logic        load_under;
    logic [3:0]  tx_idx;

    // ---- input synchronisers (CS_N idles high so reset leaves us deselected)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_CS_N};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_MOSI};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    // ---- edge recovery
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Leading edge leaves the idle (CPOL) level, trailing edge returns to it.
    assign lead_edge   = (sclk_prev == i_cpol) && (sclk_s != i_cpol);
    assign trail_edge  = (sclk_prev != i_cpol) && (sclk_s == i_cpol);
    assign sample_edge = i_cpha ? trail_edge : lead_edge;
    assign shift_edge  = i_cpha ? lead_edge  : trail_edge;
    assign cs_fall     = cs_prev && !cs_s;

    // ---- word bookkeeping
    assign n_bits    = wls_q ? 5'd16 : 5'd8;
    assign frame_end = (state_q == ACTIVE) && cs_s;
    assign rx_done   = (state_q == ACTIVE) && sample_edge && (rx_cnt_q == n_bits - 5'd1);

    // CPHA=0 reloads on the Nth shift edge; CPHA=1 keeps the MSB on the first
    // edge of a word, so the reload lands one edge later (edge N+1). A shift
    // edge coinciding with CS_N release must not consume the holding register.
    assign tx_wrap = (state_q == ACTIVE) && shift_edge && !cs_s &&
                     (i_cpha ? (tx_cnt_q == n_bits) : (tx_cnt_q == n_bits - 5'd1));
    assign load_word = (state_q == LOAD) || tx_wrap;

    // Holding register first, then a same-cycle write straight through, then fill.
    always_comb begin
        load_data  = UNDERRUN_FILL;
        load_under = 1'b1;
        if (hold_full_q) begin
            load_data  = hold_q;
            load_under = 1'b0;
        end else if (i_tx_valid) begin
            load_data  = i_tx_data;
            load_under = 1'b0;
        end
    end

    // Bit to drive on a non-reload shift edge: CPHA=0 edge k drives bit N-1-k,
    // CPHA=1 edge k drives bit N-k (tx_cnt_q holds k-1 before the increment).
    assign tx_idx = i_cpha ? 4'(n_bits - 5'd1 - tx_cnt_q) : 4'(n_bits - 5'd2 - tx_cnt_q);

    // ---- FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---- FSM next state / outputs
    always_comb begin
        state_d   = state_q;
        o_MISO_oe = 1'b0;
        o_busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) state_d = LOAD;
            end
            LOAD: begin
                o_MISO_oe = !cs_s;
                o_busy    = !cs_s;
                state_d   = cs_s ? IDLE : ACTIVE;
            end
            ACTIVE: begin
                // MISO is released in the very cycle CS_N release is seen.
                if (cs_s) begin
                    state_d = IDLE;
                end else begin
                    o_MISO_oe = 1'b1;
                    o_busy    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_word_q   <= '0;
            wls_q       <= 1'b0;
            tx_cnt_q    <= '0;
            rx_shift_q  <= '0;
            rx_cnt_q    <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;

            if (i_tx_valid && !hold_full_q) begin
                hold_q      <= i_tx_data;
                hold_full_q <= 1'b1;
            end

            // A load always leaves the holding register empty, which also
            // cancels the write above when the data is taken straight through.
            if (load_word) begin
                tx_word_q   <= load_data;
                wls_q       <= i_wls;
                miso_q      <= i_wls ? load_data[15] : load_data[7];
                hold_full_q <= 1'b0;
                underrun_q  <= load_under;
                tx_cnt_q    <= (state_q == ACTIVE && i_cpha) ? 5'd1 : 5'd0;
            end else if ((state_q == ACTIVE) && shift_edge && !cs_s) begin
                tx_cnt_q <= tx_cnt_q + 5'd1;
                if (!(i_cpha && tx_cnt_q == 5'd0)) miso_q <= tx_word_q[tx_idx];
            end

            if (state_q == LOAD) begin
                rx_cnt_q <= '0;
            end else if ((state_q == ACTIVE) && sample_edge) begin
                rx_shift_q <= {rx_shift_q[13:0], mosi_s};
                if (rx_done) begin
                    rx_cnt_q   <= '0;
                    rx_data_q  <= wls_q ? {rx_shift_q, mosi_s} : {8'h00, rx_shift_q[6:0], mosi_s};
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_cnt_q <= rx_cnt_q + 5'd1;
                end
            end

            // Partial words are dropped when CS_N is released; holding is kept.
            if (frame_end) begin
                abort_q  <= (rx_cnt_q != 5'd0) && !rx_done;
                rx_cnt_q <= '0;
                tx_cnt_q <= '0;
                miso_q   <= 1'b0;
            end
        end
    end

    assign o_tx_ready    = !hold_full_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_tx_underrun = underrun_q;
    assign o_frame_abort = abort_q;
    assign o_MISO        = miso_q;

endmodule
